// File: rtl/rx_flow_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rx_flow_ctrl_fsm
// Description : RX flow-control decoder; debounces PAUSE/RETRANS control
//               frames into registered requests with a retransmit ack hold.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_flow_ctrl_fsm #(
    parameter int                HDR_W          = 2,
    parameter int                KEY_W          = 16,
    parameter logic [HDR_W-1:0]  CTRL_HDR       = 2'b10,
    parameter logic [HDR_W-1:0]  DATA_HDR       = 2'b01,
    parameter logic [KEY_W-1:0]  IDLE_KEY       = 16'h0001,
    parameter logic [KEY_W-1:0]  PAUSE_KEY      = 16'h0010,
    parameter logic [KEY_W-1:0]  RETRANS_KEY    = 16'h1000,
    parameter int                PAUSE_THRESH   = 8,
    parameter int                RETRANS_THRESH = 8,
    parameter int                RESUME_THRESH  = 16,
    parameter int                EVT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sof,
    input  logic                    rx_up,
    input  logic [HDR_W+KEY_W-1:0]  code,
    input  logic                    retrans_ack,
    output logic                    pause_req,
    output logic                    retrans_req,
    output logic [1:0]              state,
    output logic [EVT_W-1:0]        pause_evt_cnt,
    output logic [EVT_W-1:0]        retrans_evt_cnt
);

    localparam int c_PW = $clog2(PAUSE_THRESH + 1);
    localparam int c_RW = $clog2(RETRANS_THRESH + 1);
    localparam int c_IW = $clog2(RESUME_THRESH + 1);
    localparam logic [c_PW-1:0] c_PT = c_PW'(PAUSE_THRESH);
    localparam logic [c_RW-1:0] c_RT = c_RW'(RETRANS_THRESH);
    localparam logic [c_IW-1:0] c_IT = c_IW'(RESUME_THRESH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSE   = 2'd1,
        ST_RETRANS = 2'd2,
        ST_RT_HOLD = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PW-1:0]    r_pcnt, w_pcnt_nxt;
    logic [c_RW-1:0]    r_rcnt, w_rcnt_nxt;
    logic [c_IW-1:0]    r_icnt, w_icnt_nxt;
    logic [EVT_W-1:0]   r_pevt, r_revt;
    logic               r_pause_req, r_retrans_req;

    logic [HDR_W-1:0]   w_hdr;
    logic [KEY_W-1:0]   w_key;
    logic               w_p_match, w_r_match, w_i_match;
    logic               w_p_hit, w_r_hit, w_i_hit;

    assign w_hdr     = code[HDR_W+KEY_W-1:KEY_W];
    assign w_key     = code[KEY_W-1:0];
    assign w_p_match = (w_hdr == CTRL_HDR) && (w_key == PAUSE_KEY);
    assign w_r_match = (w_hdr == CTRL_HDR) && (w_key == RETRANS_KEY);
    assign w_i_match = (w_hdr == DATA_HDR) || (w_key == IDLE_KEY);

    // Saturating run counters; hits are gated by sof so a held count never fires on its own
    always_comb begin
        w_pcnt_nxt = r_pcnt;
        w_rcnt_nxt = r_rcnt;
        w_icnt_nxt = r_icnt;
        if (sof) begin
            w_pcnt_nxt = !w_p_match ? '0 : (r_pcnt == c_PT) ? r_pcnt : r_pcnt + 1'b1;
            w_rcnt_nxt = !w_r_match ? '0 : (r_rcnt == c_RT) ? r_rcnt : r_rcnt + 1'b1;
            w_icnt_nxt = !w_i_match ? '0 : (r_icnt == c_IT) ? r_icnt : r_icnt + 1'b1;
        end
    end

    assign w_p_hit = sof && (w_pcnt_nxt == c_PT);
    assign w_r_hit = sof && (w_rcnt_nxt == c_RT);
    assign w_i_hit = sof && (w_icnt_nxt == c_IT);

    always_comb begin
        w_state_nxt = r_state;
        if (!rx_up) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_r_hit)      w_state_nxt = ST_RETRANS;
                    else if (w_p_hit) w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (w_r_hit)      w_state_nxt = ST_RETRANS;
                    else if (w_i_hit) w_state_nxt = ST_RUN;
                end
                ST_RETRANS: begin
                    if (w_i_hit)          w_state_nxt = ST_RUN;
                    else if (retrans_ack) w_state_nxt = ST_RT_HOLD;
                end
                ST_RT_HOLD: begin
                    if (w_p_hit)      w_state_nxt = ST_PAUSE;
                    else if (w_i_hit) w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pcnt        <= '0;
            r_rcnt        <= '0;
            r_icnt        <= '0;
            r_pause_req   <= 1'b0;
            r_retrans_req <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pcnt        <= rx_up ? w_pcnt_nxt : '0;
            r_rcnt        <= rx_up ? w_rcnt_nxt : '0;
            r_icnt        <= rx_up ? w_icnt_nxt : '0;
            r_pause_req   <= (w_state_nxt == ST_PAUSE);
            r_retrans_req <= (w_state_nxt == ST_RETRANS);
        end
    end

    // Entry detection compares next vs current state, so a link drop (next = RUN) never counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pevt <= '0;
            r_revt <= '0;
        end else begin
            if ((w_state_nxt == ST_PAUSE) && (r_state != ST_PAUSE))
                r_pevt <= r_pevt + 1'b1;
            if ((w_state_nxt == ST_RETRANS) && (r_state != ST_RETRANS))
                r_revt <= r_revt + 1'b1;
        end
    end

    assign state           = r_state;
    assign pause_req       = r_pause_req;
    assign retrans_req     = r_retrans_req;
    assign pause_evt_cnt   = r_pevt;
    assign retrans_evt_cnt = r_revt;

endmodule
`default_nettype wire
